// File: rtl/pipe_latch_skid_pkg.sv
// Shared types and defaults for the inter-stage pipeline latch.
// The state encoding is {skid_valid, main_valid}, so the state never drifts from the valid bits.
package pipe_latch_skid_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int PC_W_DEF   = 32;
  localparam int CNT_W_DEF  = 16;

  typedef logic [DATA_W_DEF-1:0] word_t;
  typedef logic [PC_W_DEF-1:0]   pc_t;

  localparam word_t LATCH_NOP_WORD = 32'h0000_0000;

  typedef struct packed {
    logic  valid;
    word_t data;
    pc_t   pc;
  } latch_entry_t;

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

endpackage

// File: rtl/pipe_latch_skid_entry.sv
// One valid+payload slot; clear wins over load and parks the payload at NOP / PC 0.
module pl_entry_reg #(
  parameter int                DATA_W   = 32,
  parameter int                PC_W     = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              clr_i,
  input  logic              ld_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [PC_W-1:0]   pc_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] data_o,
  output logic [PC_W-1:0]   pc_o
);

  logic              vld_q;
  logic [DATA_W-1:0] data_q;
  logic [PC_W-1:0]   pc_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      vld_q  <= 1'b0;
      data_q <= NOP_WORD;
      pc_q   <= '0;
    end else if (clr_i) begin
      vld_q  <= 1'b0;
      data_q <= NOP_WORD;
      pc_q   <= '0;
    end else if (ld_i) begin
      vld_q  <= 1'b1;
      data_q <= data_i;
      pc_q   <= pc_i;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;
  assign pc_o   = pc_q;

endmodule

// File: rtl/pipe_latch_skid.sv
// Valid/ready pipeline latch with a 2-entry skid buffer, flush-to-NOP and a saturating stall counter.
// in_ready comes straight from the skid valid flop, so no combinational path from out_ready.
module pipe_latch_skid
  import pipe_latch_skid_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                PC_W     = PC_W_DEF,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(LATCH_NOP_WORD),
  parameter int                CNT_W    = CNT_W_DEF
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_v, skid_v;
  logic [DATA_W-1:0] main_data, skid_data, main_din;
  logic [PC_W-1:0]   main_pc, skid_pc, main_pin;
  logic              main_ld, main_clr, main_sel_skid;
  logic              skid_ld, skid_clr;
  logic              in_fire, out_fire;
  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign state    = {skid_v, main_v};
  assign in_ready = ~skid_v;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_v & out_ready;

  always_comb begin
    main_ld       = 1'b0;
    main_clr      = 1'b0;
    main_sel_skid = 1'b0;
    skid_ld       = 1'b0;
    skid_clr      = 1'b0;
    if (flush) begin
      // Squash wins: a same-cycle in_fire is dropped, a same-cycle out_fire still counts downstream.
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: main_ld = in_fire;
        ST_ONE: begin
          if (in_fire && out_fire)       main_ld  = 1'b1;
          else if (in_fire)              skid_ld  = 1'b1;
          else if (out_fire)             main_clr = 1'b1;
        end
        ST_FULL: begin
          if (out_fire) begin
            main_ld       = 1'b1;
            main_sel_skid = 1'b1;
            skid_clr      = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign main_din = main_sel_skid ? skid_data : in_data;
  assign main_pin = main_sel_skid ? skid_pc   : in_pc;

  pl_entry_reg #(.DATA_W(DATA_W), .PC_W(PC_W), .NOP_WORD(NOP_WORD)) u_main (
    .CLK    (CLK),
    .nRST   (nRST),
    .clr_i  (main_clr),
    .ld_i   (main_ld),
    .data_i (main_din),
    .pc_i   (main_pin),
    .vld_o  (main_v),
    .data_o (main_data),
    .pc_o   (main_pc)
  );

  pl_entry_reg #(.DATA_W(DATA_W), .PC_W(PC_W), .NOP_WORD(NOP_WORD)) u_skid (
    .CLK    (CLK),
    .nRST   (nRST),
    .clr_i  (skid_clr),
    .ld_i   (skid_ld),
    .data_i (in_data),
    .pc_i   (in_pc),
    .vld_o  (skid_v),
    .data_o (skid_data),
    .pc_o   (skid_pc)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (main_v && !out_ready && !flush && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign out_valid = main_v;
  assign out_data  = main_v ? main_data : NOP_WORD;
  assign out_pc    = main_v ? main_pc   : '0;
  assign occupancy = {1'b0, main_v} + {1'b0, skid_v};
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_latch_skid.sv
// Randomised and directed checks of pipe_latch_skid against a depth-2 FIFO reference model.
module tb_pipe_latch_skid;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [31:0] out_pc;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;

  pipe_latch_skid dut (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_pc(out_pc),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [31:0] d; logic [31:0] p; } ent_t;
  ent_t        mq[$];
  ent_t        obs[$];
  logic [15:0] cnt_m = '0;
  int          chk_cnt = 0;
  int          pass_cnt = 0;

  // Reference: a 2-deep FIFO; accept while fewer than two held, head is the oldest.
  task automatic tick;
    bit ir, ov;
    ent_t e;
    ir = (mq.size() < 2);
    ov = (mq.size() > 0);
    @(posedge CLK);
    if (!flush && ov && !out_ready && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
    if (ov && out_ready) obs.push_back(mq.pop_front());
    if (flush) mq.delete();
    else if (in_valid && ir) begin
      e.d = in_data; e.p = in_pc;
      mq.push_back(e);
    end
    #1;
  endtask

  task automatic test_reset;
    nRST = 1'b0;
    #12;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (occupancy !== 2'd0) $display("FAIL reset_occ got %0d want 0", occupancy); else pass_cnt++;
    chk_cnt++; if (out_data !== NOP) $display("FAIL reset_out_data got %h want %h", out_data, NOP); else pass_cnt++;
    chk_cnt++; if (out_pc !== 32'd0) $display("FAIL reset_out_pc got %h want 0", out_pc); else pass_cnt++;
    chk_cnt++; if (stall_cnt !== 16'd0) $display("FAIL reset_stall got %0d want 0", stall_cnt); else pass_cnt++;
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_single;
    in_valid = 1'b1; in_data = 32'h8C22_0004; in_pc = 32'h0; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    chk_cnt++; if (out_valid !== 1'b1) $display("FAIL single_valid got %b want 1", out_valid); else pass_cnt++;
    chk_cnt++; if (out_data !== 32'h8C22_0004) $display("FAIL single_data got %h want 8c220004", out_data); else pass_cnt++;
    chk_cnt++; if (occupancy !== 2'd1) $display("FAIL single_occ got %0d want 1", occupancy); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL single_in_ready got %b want 1", in_ready); else pass_cnt++;
    tick;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL single_drain got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_stream;
    logic [31:0] w [4];
    int idx;
    bit fire;
    w[0] = 32'hA0A0_0001; w[1] = 32'hB0B0_0002; w[2] = 32'hC0C0_0003; w[3] = 32'hD0D0_0004;
    obs.delete();
    idx = 0;
    for (int c = 0; c < 20 && !(idx == 4 && mq.size() == 0); c++) begin
      in_valid  = (idx < 4);
      in_data   = (idx < 4) ? w[idx] : 32'h0;
      in_pc     = 32'(idx * 4);
      out_ready = (c != 2);
      fire = in_valid && (mq.size() < 2);
      tick;
      if (fire) idx++;
      if (c == 2) begin
        chk_cnt++; if (occupancy !== 2'd2) $display("FAIL stream_occ got %0d want 2", occupancy); else pass_cnt++;
        chk_cnt++; if (in_ready !== 1'b0) $display("FAIL stream_in_ready got %b want 0", in_ready); else pass_cnt++;
        chk_cnt++; if (out_data !== w[1]) $display("FAIL stream_held got %h want %h", out_data, w[1]); else pass_cnt++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk_cnt++; if (obs.size() != 4) $display("FAIL stream_count got %0d want 4", obs.size()); else pass_cnt++;
    for (int i = 0; i < 4 && i < obs.size(); i++) begin
      chk_cnt++; if (obs[i].d !== w[i]) $display("FAIL stream_order[%0d] got %h want %h", i, obs[i].d, w[i]); else pass_cnt++;
    end
    chk_cnt++; if (stall_cnt !== 16'd1) $display("FAIL stream_stall got %0d want 1", stall_cnt); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 32'h1000_0000 + 32'(i); in_pc = 32'h400 + 32'(4 * i);
      tick;
      chk_cnt++;
      if (out_valid !== 1'b1 || out_data !== 32'h1000_0000 + 32'(i) || out_pc !== 32'h400 + 32'(4 * i))
        $display("FAIL b2b[%0d] got v=%b d=%h p=%h want v=1 d=%h", i, out_valid, out_data, out_pc, 32'h1000_0000 + 32'(i));
      else pass_cnt++;
    end
    in_valid = 1'b0;
    tick;
    chk_cnt++; if (occupancy !== 2'd0) $display("FAIL b2b_drain got %0d want 0", occupancy); else pass_cnt++;
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 32'h2222_0000 + 32'(i); in_pc = 32'h800 + 32'(4 * i);
      tick;
    end
    chk_cnt++; if (occupancy !== 2'd2) $display("FAIL flush_fill got %0d want 2", occupancy); else pass_cnt++;
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    tick;
    flush = 1'b0; in_valid = 1'b0;
    chk_cnt++; if (occupancy !== 2'd0) $display("FAIL flush_occ got %0d want 0", occupancy); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (out_data !== NOP) $display("FAIL flush_data got %h want %h", out_data, NOP); else pass_cnt++;
    chk_cnt++; if (out_pc !== 32'd0) $display("FAIL flush_pc got %h want 0", out_pc); else pass_cnt++;
    chk_cnt++; if (stall_cnt !== cnt_m) $display("FAIL flush_stall got %0d want %0d", stall_cnt, cnt_m); else pass_cnt++;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk_cnt++;
      if (out_valid !== 1'b0 || out_data === 32'hDEAD_BEEF)
        $display("FAIL flush_leak[%0d] got v=%b d=%h want v=0", i, out_valid, out_data);
      else pass_cnt++;
    end
  endtask

  task automatic test_random;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_data   = $urandom;
      in_pc     = {$urandom_range(0, 16'hFFFF), 2'b00};
      tick;
      chk_cnt++; if (out_valid !== (mq.size() > 0)) $display("FAIL rnd_valid c=%0d got %b want %b", c, out_valid, mq.size() > 0); else pass_cnt++;
      chk_cnt++; if (occupancy !== 2'(mq.size())) $display("FAIL rnd_occ c=%0d got %0d want %0d", c, occupancy, mq.size()); else pass_cnt++;
      chk_cnt++; if (in_ready !== (mq.size() < 2)) $display("FAIL rnd_in_ready c=%0d got %b want %b", c, in_ready, mq.size() < 2); else pass_cnt++;
      chk_cnt++;
      if (out_data !== ((mq.size() > 0) ? mq[0].d : NOP)) $display("FAIL rnd_data c=%0d got %h want %h", c, out_data, (mq.size() > 0) ? mq[0].d : NOP);
      else pass_cnt++;
      chk_cnt++;
      if (out_pc !== ((mq.size() > 0) ? mq[0].p : 32'd0)) $display("FAIL rnd_pc c=%0d got %h want %h", c, out_pc, (mq.size() > 0) ? mq[0].p : 32'd0);
      else pass_cnt++;
      chk_cnt++; if (stall_cnt !== cnt_m) $display("FAIL rnd_stall c=%0d got %0d want %0d", c, stall_cnt, cnt_m); else pass_cnt++;
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick; tick;
  endtask

  task automatic test_stall_sat;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h5A5A_0000; in_pc = 32'hC00;
    tick; tick;
    in_valid = 1'b0;
    for (int i = 0; i < 70000; i++) tick;
    chk_cnt++; if (stall_cnt !== 16'hFFFF) $display("FAIL sat_cnt got %h want ffff", stall_cnt); else pass_cnt++;
    chk_cnt++; if (occupancy !== 2'd2) $display("FAIL sat_occ got %0d want 2", occupancy); else pass_cnt++;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk_cnt++; if (stall_cnt !== 16'hFFFF) $display("FAIL sat_after_flush got %h want ffff", stall_cnt); else pass_cnt++;
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h7777_0001; in_pc = 32'h100;
    tick;
    in_valid = 1'b0;
    chk_cnt++; if (occupancy !== 2'd1) $display("FAIL arst_pre_occ got %0d want 1", occupancy); else pass_cnt++;
    #2 nRST = 1'b0;
    #1;
    mq.delete(); cnt_m = '0;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL arst_valid got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (occupancy !== 2'd0) $display("FAIL arst_occ got %0d want 0", occupancy); else pass_cnt++;
    chk_cnt++; if (out_data !== NOP) $display("FAIL arst_data got %h want %h", out_data, NOP); else pass_cnt++;
    chk_cnt++; if (stall_cnt !== 16'd0) $display("FAIL arst_stall got %0d want 0", stall_cnt); else pass_cnt++;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    tick;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL arst_in_ready got %b want 1", in_ready); else pass_cnt++;
    chk_cnt++; if (occupancy !== 2'd0) $display("FAIL arst_post_occ got %0d want 0", occupancy); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_single;
    test_stream;
    test_back_to_back;
    test_flush;
    test_random;
    test_stall_sat;
    test_async_reset;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
